hi_xcorr_ssp_tx: RTL and testbench
==================================

// Module: hi_xcorr_ssp_tx
// PURPOSE
//  Downstream of the HF I/Q correlator. Accepts 8-bit signed I/Q correlation pairs
//  (one strobe per report), buffers them in a small FIFO and serialises each pair to
//  the ARM over SSP as two 8-bit frames (I, then Q), MSB first.
//  Decouples correlator report timing from the SSP link; reports overflow when the ARM
//  link cannot keep up.
// PARAMETERS
//  FIFO_DEPTH  4  pair entries buffered; power of 2, >=2
//  SSP_DIV     4  adc_clk cycles per SSP bit; even, >=2
// PORTS
//  adc_clk     in   1   sample clock, all logic on rising edge
//  rst_n       in   1   async active-low reset
//  corr_i      in   8   signed I correlation; in snoop mode LSB carries reader AM bit
//  corr_q      in   8   signed Q correlation, same convention
//  corr_valid  in   1   1-cycle strobe; corr_i/corr_q valid this cycle
//  ovf_clr     in   1   clears the overflow flag
//  ssp_clk     out  1   SSP bit clock; ARM samples ssp_din on its rising edge
//  ssp_frame   out  1   high for the first bit period of each 8-bit frame
//  ssp_din     out  1   serial data, MSB first
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently held
//  overflow    out  1   sticky: a pair was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (async, any time, incl. mid-word): ssp_clk=0, ssp_frame=0, ssp_din=0,
//   fifo_level=0, overflow=0, FSM=IDLE, counters=0; the partial word is discarded.
//  Push: corr_valid && (!full || pop same cycle) -> {corr_i,corr_q} written.
//   corr_valid && full && !pop -> pair dropped; overflow<=1.
//   ovf_clr and a drop in the same cycle -> overflow=1; set wins.
//  Pop in the same cycle as push when the FIFO is empty: not allowed.
//   The pushed word is first poppable on the next cycle.
//  FSM IDLE: when !empty, pop the head into 16-bit shreg; bit_cnt=0, ph_cnt=0 -> SHIFT.
//  FSM SHIFT: ph_cnt counts 0..SSP_DIV-1 for each bit. Output rules:
//   ssp_clk = (ph_cnt >= SSP_DIV/2); ssp_din = shreg[15], changes only with ph_cnt=0.
//   ssp_frame = 1 while bit_cnt is 0 or 8.
//   At ph_cnt=SSP_DIV-1: shreg <<= 1; bit_cnt++.
//  End of bit 15 (last phase):
//   - FIFO non-empty -> pop and reload in that cycle; the next word's bit 0 starts on
//     the next cycle. No idle gap.
//   - FIFO empty -> IDLE; ssp_clk=0, ssp_frame=0, ssp_din holds 0.
//  Latency: strobe at cycle N into an empty FIFO, FSM in IDLE:
//   pop at N+1; ssp_din = corr_i[7] and ssp_frame=1 from N+2.
//   First ssp_clk rising edge at N+2+SSP_DIV/2.
//  Throughput: one pair per 16*SSP_DIV cycles (64 at default), which matches the
//   correlator report rate. The FIFO absorbs jitter only.
//  fifo_level is a registered count; it updates the cycle after push/pop.
//   Push and pop in the same cycle -> unchanged.
// CONFIGURATION
//  HI_XCORR_DROP_CNT_EN defined:
//   - adds output drop_cnt[7:0], reset 0; +1 per dropped pair, saturates at 255;
//     cleared by ovf_clr.
//   - a drop in the same cycle as ovf_clr -> drop_cnt=1.
//  HI_XCORR_DROP_CNT_EN undefined: no drop_cnt port or logic; overflow flag only.
// STRUCTURE
//  Package hi_xcorr_pkg: CORR_W=8, SSP_WORD_W=16, state enum {IDLE, SHIFT},
//   localparam for frame-start bit indices (0, 8).
//  Sub-module hi_xcorr_fifo: sync FIFO; push, pop, full, empty, level; no fall-through.
//  Top: FSM, ph_cnt, bit_cnt, shreg, overflow/drop logic.
// TESTING
//  1 Single pair I=8'hA5, Q=8'h3C after reset, SSP_DIV=4:
//    - ARM model samples at ssp_clk rise and sees 1010_0101 then 0011_1100;
//    - ssp_frame high for exactly 4 cycles at bits 0 and 8;
//    - first rise at N+4.
//  2 Back-to-back: 4 pairs, one every 64 cycles:
//    - continuous ssp_clk with no gap between words;
//    - fifo_level never exceeds 1; overflow stays 0.
//  3 Burst of 6 strobes on consecutive cycles, depth 4:
//    - pair 1 popped immediately; pairs 2-5 buffered; pair 6 dropped;
//    - overflow=1; with DROP_CNT_EN, drop_cnt=1;
//    - exactly 5 words serialised, in order.
//  4 Overflow and ovf_clr in the same cycle -> overflow stays 1.
//    A later ovf_clr alone -> overflow 0; drop_cnt 0.
//  5 rst_n asserted at bit 5 of a word, with 2 entries queued:
//    - all outputs 0 asynchronously; fifo_level=0;
//    - after release, the next strobe serialises cleanly from bit 0.
//  6 Saturation (DROP_CNT_EN): hold the FIFO full, issue 300 strobes -> drop_cnt=255.

Source files
------------

// File: rtl/hi_xcorr_pkg.sv
// Shared types and constants for the HF correlator SSP transmitter.
// Frame strobes mark the I byte (bit 0) and the Q byte (bit 8) of each 16-bit word.
package hi_xcorr_pkg;
  localparam int CORR_W     = 8;
  localparam int SSP_WORD_W = 2 * CORR_W;
  localparam int BIT_CNT_W  = $clog2(SSP_WORD_W);

  localparam logic [BIT_CNT_W-1:0] FRAME_BIT_I = BIT_CNT_W'(0);
  localparam logic [BIT_CNT_W-1:0] FRAME_BIT_Q = BIT_CNT_W'(CORR_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic is_frame_bit(input logic [BIT_CNT_W-1:0] bit_idx);
    return (bit_idx == FRAME_BIT_I) || (bit_idx == FRAME_BIT_Q);
  endfunction
endpackage

// File: rtl/hi_xcorr_fifo.sv
// Synchronous FIFO, no fall-through: a pushed word is visible at the head one cycle later.
// Level is registered; push is trusted by the caller to be legal (not full, or popping).
module hi_xcorr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_comb begin
    level_d = level_q;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
endmodule

// File: rtl/hi_xcorr_ssp_tx.sv
// Buffers I/Q correlation pairs and serialises each as two MSB-first SSP frames (I then Q).
// Strobe to first data bit is 2 cycles; a full FIFO drops pairs (sticky overflow, optional drop_cnt via HI_XCORR_DROP_CNT_EN).
module hi_xcorr_ssp_tx
  import hi_xcorr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SSP_DIV    = 4
) (
  input  logic                         adc_clk,
  input  logic                         rst_n,
  input  logic [CORR_W-1:0]            corr_i,
  input  logic [CORR_W-1:0]            corr_q,
  input  logic                         corr_valid,
  input  logic                         ovf_clr,
  output logic                         ssp_clk,
  output logic                         ssp_frame,
  output logic                         ssp_din,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow
`ifdef HI_XCORR_DROP_CNT_EN
  ,
  output logic [7:0]                   drop_cnt
`endif
);
  localparam int PH_W = $clog2(SSP_DIV);

  state_e                  state_q;
  logic [PH_W-1:0]         ph_cnt_q;
  logic [BIT_CNT_W-1:0]    bit_cnt_q;
  logic [SSP_WORD_W-1:0]   shreg_q;
  logic                    overflow_q, overflow_d;

  logic                    fifo_full, fifo_empty, fifo_push, fifo_pop, drop;
  logic [SSP_WORD_W-1:0]   fifo_rdata;
  logic                    last_ph, last_bit;

  assign last_ph  = (ph_cnt_q == PH_W'(SSP_DIV - 1));
  assign last_bit = (bit_cnt_q == BIT_CNT_W'(SSP_WORD_W - 1));

  // Reload on the last phase of bit 15 keeps back-to-back words gap-free.
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == IDLE) || (state_q == SHIFT && last_ph && last_bit));
  assign fifo_push = corr_valid && (!fifo_full || fifo_pop);
  assign drop      = corr_valid && fifo_full && !fifo_pop;

  hi_xcorr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SSP_WORD_W)
  ) u_fifo (
    .clk_i   (adc_clk),
    .rst_n_i (rst_n),
    .push_i  (fifo_push),
    .wdata_i ({corr_i, corr_q}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ph_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            shreg_q   <= fifo_rdata;
            ph_cnt_q  <= '0;
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last_ph) begin
            ph_cnt_q <= ph_cnt_q + PH_W'(1);
          end else begin
            ph_cnt_q <= '0;
            if (!last_bit) begin
              shreg_q   <= shreg_q << 1;
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            end else if (fifo_pop) begin
              shreg_q   <= fifo_rdata;
              bit_cnt_q <= '0;
            end else begin
              shreg_q   <= '0;
              bit_cnt_q <= '0;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ssp_clk   = (state_q == SHIFT) && (ph_cnt_q >= PH_W'(SSP_DIV / 2));
  assign ssp_din   = (state_q == SHIFT) && shreg_q[SSP_WORD_W-1];
  assign ssp_frame = (state_q == SHIFT) && is_frame_bit(bit_cnt_q);

  // A drop in the same cycle as a clear leaves the flag set.
  assign overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

`ifdef HI_XCORR_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr)                          drop_cnt_d = {7'd0, drop};
    else if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_hi_xcorr_ssp_tx.sv
// Bench for hi_xcorr_ssp_tx: an ARM-side SSP receiver model rebuilds words at ssp_clk rises
// and compares them with the pairs the bench expects to have been accepted.
module tb_hi_xcorr_ssp_tx;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    corr_i = '0, corr_q = '0;
  logic          corr_valid = 1'b0, ovf_clr = 1'b0;
  logic          ssp_clk, ssp_frame, ssp_din, overflow;
  logic [LW-1:0] fifo_level;
`ifdef HI_XCORR_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int n_chk = 0, n_pass = 0, cyc = 0;

  logic [15:0] exp_q[$], got_q[$], gotf_q[$];
  int          runs_q[$];
  logic [15:0] mon_w = '0, mon_f = '0;
  int          mon_n = 0, fr_run = 0, last_rise = -1, first_rise = -1, bad_gaps = 0, lvl_max = 0;
  bit          gap_en = 1'b0, prev_clk = 1'b0;

  hi_xcorr_ssp_tx #(.FIFO_DEPTH(DEPTH), .SSP_DIV(DIV)) dut (
    .adc_clk    (clk),
    .rst_n      (rst_n),
    .corr_i     (corr_i),
    .corr_q     (corr_q),
    .corr_valid (corr_valid),
    .ovf_clr    (ovf_clr),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef HI_XCORR_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ARM receiver model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_clk = 1'b0;
      mon_n    = 0;
      fr_run   = 0;
    end else begin
      if (ssp_clk && !prev_clk) begin
        mon_w = {mon_w[14:0], ssp_din};
        mon_f = {mon_f[14:0], ssp_frame};
        mon_n++;
        if (gap_en && last_rise >= 0 && (cyc - last_rise) != DIV) bad_gaps++;
        last_rise = cyc;
        if (first_rise < 0) first_rise = cyc;
        if (mon_n == 16) begin
          got_q.push_back(mon_w);
          gotf_q.push_back(mon_f);
          mon_n = 0;
        end
      end
      prev_clk = ssp_clk;
      if (ssp_frame) fr_run++;
      else if (fr_run > 0) begin
        runs_q.push_back(fr_run);
        fr_run = 0;
      end
      if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
    end
  end

  task automatic drive(input logic v, input logic [7:0] i, input logic [7:0] q, input logic c);
    @(posedge clk);
    #1;
    corr_valid = v;
    corr_i     = i;
    corr_q     = q;
    ovf_clr    = c;
  endtask

  task automatic wait_words(input int n);
    for (int k = 0; k < 4000 && got_q.size() < n; k++) @(posedge clk);
    repeat (2 * DIV + 4) @(posedge clk);
  endtask

  task automatic clear_mon();
    got_q.delete();
    gotf_q.delete();
    runs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if ({ssp_clk, ssp_frame, ssp_din, overflow} !== 4'b0) $display("FAIL reset_outs got=%b exp=0000", {ssp_clk, ssp_frame, ssp_din, overflow});
    else n_pass++;
    n_chk++;
    if (fifo_level !== '0) $display("FAIL reset_level got=%0d exp=0", fifo_level);
    else n_pass++;
`ifdef HI_XCORR_DROP_CNT_EN
    n_chk++;
    if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt);
    else n_pass++;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if ({ssp_clk, ssp_frame, ssp_din, fifo_level} !== '0) $display("FAIL idle_after_reset got=%b exp=0", {ssp_clk, ssp_frame, ssp_din, fifo_level});
    else n_pass++;
  endtask

  task automatic test_single();
    int t0;
    clear_mon();
    first_rise = -1;
    drive(1'b1, 8'hA5, 8'h3C, 1'b0);
    t0 = cyc;
    exp_q.push_back(16'hA53C);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    wait_words(1);
    n_chk++;
    if (got_q.size() != 1 || got_q[0] !== 16'hA53C) $display("FAIL single_word n=%0d got=%h exp=a53c", got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
    else n_pass++;
    n_chk++;
    if (gotf_q.size() != 1 || gotf_q[0] !== 16'h8080) $display("FAIL single_frame_bits got=%h exp=8080", (gotf_q.size() > 0) ? gotf_q[0] : 16'hxxxx);
    else n_pass++;
    n_chk++;
    if (runs_q.size() != 2 || runs_q[0] != DIV || runs_q[1] != DIV)
      $display("FAIL single_frame_len runs=%0d first=%0d exp=2 runs of %0d", runs_q.size(), (runs_q.size() > 0) ? runs_q[0] : -1, DIV);
    else n_pass++;
    n_chk++;
    if (first_rise - t0 != 2 + DIV / 2) $display("FAIL single_latency got=%0d exp=%0d", first_rise - t0, 2 + DIV / 2);
    else n_pass++;
    n_chk++;
    if ({ssp_clk, ssp_frame, ssp_din} !== 3'b000) $display("FAIL single_idle_outs got=%b exp=000", {ssp_clk, ssp_frame, ssp_din});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] i, q;
    clear_mon();
    last_rise = -1;
    bad_gaps  = 0;
    lvl_max   = 0;
    gap_en    = 1'b1;
    for (int p = 0; p < 4; p++) begin
      i = 8'($urandom);
      q = 8'($urandom);
      exp_q.push_back({i, q});
      drive(1'b1, i, q, 1'b0);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      repeat (62) @(posedge clk);
    end
    wait_words(4);
    gap_en = 1'b0;
    n_chk++;
    if (got_q.size() != exp_q.size()) $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_chk++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k] || gotf_q[k] !== 16'h8080)
        $display("FAIL b2b_word%0d got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 16'hxxxx, exp_q[k]);
      else n_pass++;
    end
    n_chk++;
    if (bad_gaps != 0) $display("FAIL b2b_clk_gaps got=%0d exp=0", bad_gaps);
    else n_pass++;
    n_chk++;
    if (lvl_max > 1) $display("FAIL b2b_level_max got=%0d exp<=1", lvl_max);
    else n_pass++;
    n_chk++;
    if (overflow !== 1'b0) $display("FAIL b2b_overflow got=%b exp=0", overflow);
    else n_pass++;
  endtask

  task automatic test_burst();
    logic [7:0] i, q;
    clear_mon();
    // Into an idle link, one pair goes straight out and DEPTH more are held; the rest drop.
    for (int p = 0; p < 6; p++) begin
      i = 8'($urandom);
      q = 8'($urandom);
      if (p < DEPTH + 1) exp_q.push_back({i, q});
      drive(1'b1, i, q, 1'b0);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    n_chk++;
    if (overflow !== 1'b1) $display("FAIL burst_overflow got=%b exp=1", overflow);
    else n_pass++;
    n_chk++;
    if (int'(fifo_level) != DEPTH) $display("FAIL burst_level got=%0d exp=%0d", fifo_level, DEPTH);
    else n_pass++;
`ifdef HI_XCORR_DROP_CNT_EN
    n_chk++;
    if (drop_cnt !== 8'd1) $display("FAIL burst_drop_cnt got=%0d exp=1", drop_cnt);
    else n_pass++;
`endif
    wait_words(DEPTH + 1);
    n_chk++;
    if (got_q.size() != exp_q.size()) $display("FAIL burst_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_chk++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k])
        $display("FAIL burst_word%0d got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 16'hxxxx, exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_ovf_collision();
    logic [7:0] i, q;
    clear_mon();
    for (int p = 0; p < DEPTH + 1; p++) begin
      i = 8'($urandom);
      q = 8'($urandom);
      exp_q.push_back({i, q});
      drive(1'b1, i, q, 1'b0);
    end
    drive(1'b1, 8'hEE, 8'hEE, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    n_chk++;
    if (overflow !== 1'b1) $display("FAIL collision_overflow got=%b exp=1", overflow);
    else n_pass++;
`ifdef HI_XCORR_DROP_CNT_EN
    n_chk++;
    if (drop_cnt !== 8'd1) $display("FAIL collision_drop_cnt got=%0d exp=1", drop_cnt);
    else n_pass++;
`endif
    wait_words(DEPTH + 1);
    n_chk++;
    if (got_q.size() != exp_q.size()) $display("FAIL collision_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_chk++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k])
        $display("FAIL collision_word%0d got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 16'hxxxx, exp_q[k]);
      else n_pass++;
    end
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    n_chk++;
    if (overflow !== 1'b0) $display("FAIL clear_overflow got=%b exp=0", overflow);
    else n_pass++;
`ifdef HI_XCORR_DROP_CNT_EN
    n_chk++;
    if (drop_cnt !== 8'd0) $display("FAIL clear_drop_cnt got=%0d exp=0", drop_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_midword();
    logic [7:0] i, q;
    clear_mon();
    for (int p = 0; p < 3; p++) drive(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    for (int k = 0; k < 500 && mon_n < 6; k++) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (ssp_clk !== 1'b0 || ssp_din !== 1'b0 || ssp_frame !== 1'b0)
      $display("FAIL midreset_ssp got=%b exp=000", {ssp_clk, ssp_frame, ssp_din});
    else n_pass++;
    n_chk++;
    if (fifo_level !== '0) $display("FAIL midreset_level got=%0d exp=0", fifo_level);
    else n_pass++;
    n_chk++;
    if (overflow !== 1'b0) $display("FAIL midreset_overflow got=%b exp=0", overflow);
    else n_pass++;
    got_q.delete();
    gotf_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    n_chk++;
    if (got_q.size() != 0 || fifo_level !== '0) $display("FAIL midreset_residue words=%0d level=%0d exp=0", got_q.size(), fifo_level);
    else n_pass++;
    i = 8'($urandom);
    q = 8'($urandom);
    exp_q.push_back({i, q});
    drive(1'b1, i, q, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    wait_words(1);
    n_chk++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0] || gotf_q[0] !== 16'h8080)
      $display("FAIL midreset_next_word got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : 16'hxxxx, exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_random_spacing();
    logic [7:0] i, q;
    clear_mon();
    for (int p = 0; p < 6; p++) begin
      i = 8'($urandom);
      q = 8'($urandom);
      exp_q.push_back({i, q});
      drive(1'b1, i, q, 1'b0);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      repeat ($urandom_range(150, 64)) @(posedge clk);
    end
    wait_words(6);
    n_chk++;
    if (got_q.size() != exp_q.size()) $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_chk++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k])
        $display("FAIL rand_word%0d got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 16'hxxxx, exp_q[k]);
      else n_pass++;
    end
    n_chk++;
    if (overflow !== 1'b0) $display("FAIL rand_overflow got=%b exp=0", overflow);
    else n_pass++;
  endtask

`ifdef HI_XCORR_DROP_CNT_EN
  task automatic test_saturation();
    for (int p = 0; p < 300; p++) drive(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    n_chk++;
    if (drop_cnt !== 8'd255) $display("FAIL sat_drop_cnt got=%0d exp=255", drop_cnt);
    else n_pass++;
    n_chk++;
    if (overflow !== 1'b1) $display("FAIL sat_overflow got=%b exp=1", overflow);
    else n_pass++;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_burst();
    test_ovf_collision();
    test_reset_midword();
    test_random_spacing();
`ifdef HI_XCORR_DROP_CNT_EN
    test_saturation();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
